// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer and its FIFOs.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_TAG_W  = 4;
    localparam logic [ALU_DATA_W-1:0] ALU_DIV0_Q = 8'hFF;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_DIV = 3'b011
    } alu_op_e;

    // op kept as raw bits so that the 1xx pass-through codes survive storage
    typedef struct packed {
        logic [2:0]            op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_cmd_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] q;
        logic                  cout;
        logic [ALU_TAG_W-1:0]  tag;
        logic                  err;
    } alu_rsp_t;

    function automatic logic is_div0(logic [2:0] op, logic [ALU_DATA_W-1:0] b);
        return (op == ALU_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-side signals of the issuer; slave is the issuer's view.
interface alu_cmd_issuer_if #(
    parameter int unsigned TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [2:0]       alu_ctl;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_q;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_q;
    logic             rsp_cout;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [2:0]       inflight;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_q, alu_cout, rsp_ready,
        output cmd_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_q, rsp_cout, rsp_tag,
               rsp_err, inflight
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_q, alu_cout, rsp_ready,
        input  cmd_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_q, rsp_cout, rsp_tag,
               rsp_err, inflight
    );
endinterface

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with registered count; head is shown combinationally from storage.
module alu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers tagged ALU commands, issues them with response-space credits and returns
// results in order; an op is only issued when its result is guaranteed a slot.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned TAG_W     = ALU_TAG_W
) (
    input logic              clk,
    input logic              rst_n,
    alu_cmd_issuer_if.slave  bus
);
    localparam int unsigned CCW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RCW = $clog2(RSP_DEPTH) + 1;

    alu_cmd_t             w_cmd_in;
    alu_cmd_t             w_cmd_head;
    logic                 w_cmd_push;
    logic                 w_cmd_full;
    logic                 w_cmd_empty;
    logic [CCW-1:0]       w_cmd_count;
    alu_rsp_t             w_rsp_in;
    alu_rsp_t             w_rsp_head;
    logic                 w_rsp_full;
    logic                 w_rsp_empty;
    logic [RCW-1:0]       w_rsp_count;
    logic                 w_issue;
    logic [2:0]           w_inflight;
    logic                 w_unused_full;

    logic [ALU_LAT:0]     r_vld;
    logic [ALU_LAT:0]     r_err;
    logic [ALU_TAG_W-1:0] r_tag [ALU_LAT+1];
    logic [2:0]           r_alu_ctl;
    logic [7:0]           r_alu_a;
    logic [7:0]           r_alu_b;

    always_comb begin
        w_cmd_in     = '0;
        w_cmd_in.op  = bus.cmd_op;
        w_cmd_in.a   = bus.cmd_a;
        w_cmd_in.b   = bus.cmd_b;
        w_cmd_in.tag = ALU_TAG_W'(bus.cmd_tag);
    end

    assign bus.cmd_ready = (32'(w_cmd_count) < CMD_DEPTH);
    assign w_cmd_push    = bus.cmd_valid && bus.cmd_ready;

    alu_sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cmd_push),
        .i_wdata (w_cmd_in),
        .i_pop   (w_issue),
        .o_rdata (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= int'(ALU_LAT); i++) w_inflight = w_inflight + 3'(r_vld[i]);
    end

    // Credits count both stored and in-flight results; a same-cycle response pop is not used.
    assign w_issue = !w_cmd_empty && ((32'(w_rsp_count) + 32'(w_inflight)) < RSP_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_err     <= '0;
            for (int i = 0; i <= int'(ALU_LAT); i++) r_tag[i] <= '0;
            r_alu_ctl <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else begin
            for (int i = int'(ALU_LAT); i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            r_vld[0] <= w_issue;
            r_err[0] <= is_div0(w_cmd_head.op, w_cmd_head.b);
            r_tag[0] <= w_cmd_head.tag;
            if (w_issue) begin
                r_alu_ctl <= w_cmd_head.op;
                r_alu_a   <= w_cmd_head.a;
                r_alu_b   <= w_cmd_head.b;
            end
        end
    end

    assign bus.alu_ctl = r_alu_ctl;
    assign bus.alu_a   = r_alu_a;
    assign bus.alu_b   = r_alu_b;
    assign bus.inflight = w_inflight;

    always_comb begin
        w_rsp_in.tag = r_tag[ALU_LAT];
        w_rsp_in.err = r_err[ALU_LAT];
        if (r_err[ALU_LAT]) begin
            w_rsp_in.q    = ALU_DIV0_Q;
            w_rsp_in.cout = 1'b0;
        end else begin
            w_rsp_in.q    = bus.alu_q;
            w_rsp_in.cout = bus.alu_cout;
        end
    end

    alu_sync_fifo #(.WIDTH($bits(alu_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_vld[ALU_LAT]),
        .i_wdata (w_rsp_in),
        .i_pop   (bus.rsp_ready),
        .o_rdata (w_rsp_head),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    // Overflow is excluded by the credit rule, so the full flags carry no extra information.
    assign w_unused_full = w_cmd_full | w_rsp_full;

    assign bus.rsp_valid = !w_rsp_empty;
    assign bus.rsp_q     = w_rsp_head.q;
    assign bus.rsp_cout  = w_rsp_head.cout;
    assign bus.rsp_tag   = TAG_W'(w_rsp_head.tag);
    assign bus.rsp_err   = w_rsp_head.err;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural 1-cycle ALU, response scoreboard, vector table.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        alu_rsp_t   exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.TAG_W(4)) bus ();

    alu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       n_acc = 0;
    alu_rsp_t exp_q[$];
    int       pop_cyc[$];
    vec_t     tbl[10];

    function automatic logic [8:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        case (op)
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  begin p = a * b; return p[8:0]; end
            3'b011:  return (b == 8'd0) ? 9'h000 : {1'b0, a / b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    function automatic alu_rsp_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                       logic [3:0] tag);
        alu_rsp_t   r;
        logic [8:0] v;
        v = alu_ref(op, a, b);
        r.tag = tag;
        if (op == 3'b011 && b == 8'd0) begin
            r.q = 8'hFF; r.cout = 1'b0; r.err = 1'b1;
        end else begin
            r.q = v[7:0]; r.cout = v[8]; r.err = 1'b0;
        end
        return r;
    endfunction

    // Registered ALU: result of inputs present before an edge appears after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {bus.alu_cout, bus.alu_q} <= 9'h000;
        else {bus.alu_cout, bus.alu_q} <= alu_ref(bus.alu_ctl, bus.alu_a, bus.alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] tag, input logic [7:0] q,
                           input logic cout, input logic err);
        tbl[i].op = op; tbl[i].a = a; tbl[i].b = b; tbl[i].tag = tag;
        tbl[i].exp.q = q; tbl[i].exp.cout = cout; tbl[i].exp.tag = tag; tbl[i].exp.err = err;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input alu_rsp_t exp);
        int  n;
        logic ok;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            n++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(exp);
            n_acc++;
        end else begin
            chk("send_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_drain(input int want_acc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || n_acc < want_acc) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_tag = '0; bus.rsp_ready = 1'b0;

        set_vec(0, 3'b001, 8'd5,   8'd7,   4'd1,  8'hFE, 1'b1, 1'b0);
        set_vec(1, 3'b010, 8'd20,  8'd13,  4'd2,  8'h04, 1'b1, 1'b0);
        set_vec(2, 3'b011, 8'd100, 8'd7,   4'd3,  8'd14, 1'b0, 1'b0);
        set_vec(3, 3'b011, 8'd9,   8'd0,   4'd5,  8'hFF, 1'b0, 1'b1);
        set_vec(4, 3'b000, 8'd1,   8'd1,   4'd6,  8'd2,  1'b0, 1'b0);
        set_vec(5, 3'b000, 8'd255, 8'd1,   4'd7,  8'h00, 1'b1, 1'b0);
        set_vec(6, 3'b001, 8'd0,   8'd0,   4'd8,  8'h00, 1'b0, 1'b0);
        set_vec(7, 3'b010, 8'd255, 8'd255, 4'd9,  8'h01, 1'b0, 1'b0);
        set_vec(8, 3'b011, 8'd0,   8'd0,   4'd10, 8'hFF, 1'b0, 1'b1);
        set_vec(9, 3'b110, 8'd128, 8'd128, 4'd11, 8'h00, 1'b1, 1'b0);

        fork
            forever begin : monitor
                alu_rsp_t got;
                alu_rsp_t e;
                @(negedge clk);
                cyc++;
                if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                    got.q = bus.rsp_q; got.cout = bus.rsp_cout;
                    got.tag = bus.rsp_tag; got.err = bus.rsp_err;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(got), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rsp_tag%0d", e.tag), 32'(got), 32'(e));
                        pop_cyc.push_back(cyc);
                    end
                end
            end
        join_none

        // Reset values
        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_ctl",   32'(bus.alu_ctl),   32'd0);
        chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
        chk("rst_alu_b",     32'(bus.alu_b),     32'd0);
        chk("rst_rsp_q",     32'(bus.rsp_q),     32'd0);
        chk("rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
        chk("rst_rsp_tag",   32'(bus.rsp_tag),   32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_inflight",  32'(bus.inflight),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with latency: accept E0, ALU inputs after E1, rsp_valid after E3
        bus.rsp_ready = 1'b1;
        send(3'b000, 8'd200, 8'd100, 4'd3, model(3'b000, 8'd200, 8'd100, 4'd3));
        chk("t1_model_q", 32'(exp_q[0].q), 32'd44);
        @(posedge clk); #1;
        chk("t1_alu_ctl",  32'(bus.alu_ctl),  32'd0);
        chk("t1_alu_a",    32'(bus.alu_a),    32'd200);
        chk("t1_alu_b",    32'(bus.alu_b),    32'd100);
        chk("t1_inflight", 32'(bus.inflight), 32'd1);
        @(posedge clk); #1;
        chk("t1_valid_e2", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_e3", 32'(bus.rsp_valid), 32'd1);
        wait_drain(1);

        // Table vectors back-to-back, checked in order by the scoreboard
        n_acc = 0;
        for (int i = 0; i < 10; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp);
        wait_drain(10);

        // Pass-through op code
        send(3'b101, 8'd3, 8'd4, 4'd12, tbl[0].exp);
        void'(exp_q.pop_back());
        exp_q.push_back('{q: 8'd7, cout: 1'b0, tag: 4'd12, err: 1'b0});
        @(posedge clk); #1;
        chk("t6_alu_ctl", 32'(bus.alu_ctl), 32'h5);
        wait_drain(0);

        // Backpressure: 8 accepted, 4 issued; then 10 responses on 10 consecutive cycles
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        fork
            for (int i = 0; i < 10; i++) begin
                logic [2:0] op;
                logic [7:0] a;
                logic [7:0] b;
                op = 3'(i % 4);
                a = 8'(i * 23 + 5);
                b = (i % 3 == 0) ? 8'd0 : 8'(i * 7);
                send(op, a, b, 4'(i), model(op, a, b, 4'(i)));
            end
        join_none
        repeat (20) @(posedge clk);
        #1;
        chk("t4_accepted",  32'(n_acc),          32'd8);
        chk("t4_cmd_ready", 32'(bus.cmd_ready),  32'd0);
        chk("t4_inflight",  32'(bus.inflight),   32'd0);
        chk("t4_rsp_valid", 32'(bus.rsp_valid),  32'd1);
        pop_cyc.delete();
        bus.rsp_ready = 1'b1;
        wait_drain(10);
        chk("t4_pops", 32'(pop_cyc.size()), 32'd10);
        if (pop_cyc.size() == 10) chk("t4_span", 32'(pop_cyc[9] - pop_cyc[0]), 32'd9);

        // Reset with three commands in flight
        n_acc = 0;
        for (int i = 0; i < 3; i++) send(3'b000, 8'(i), 8'd1, 4'(i), model(3'b000, 8'(i), 8'd1, 4'(i)));
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_alu_ctl",   32'(bus.alu_ctl),   32'd0);
        chk("t5_alu_a",     32'(bus.alu_a),     32'd0);
        chk("t5_inflight",  32'(bus.inflight),  32'd0);
        chk("t5_rsp_q",     32'(bus.rsp_q),     32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus.rsp_valid) seen++;
            end
            chk("t5_no_rsp", 32'(seen), 32'd0);
        end
        chk("t5_ready_after", 32'(bus.cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
